// File: rtl/bpu_if.sv
// bpu_if: fetch-side prediction and execute-side training signals of the branch predictor
interface bpu_if #(parameter int XLEN = 32);
  logic [XLEN-1:0] pc_i, next_pc_o, upd_pc_i, upd_target_i;
  logic ce_i, next_taken_o;
  logic upd_valid_i, upd_taken_i, upd_cond_i, upd_mispred_i, invalidate_i;
  logic [31:0] stat_upd_o, stat_mispred_o;
  modport master(
    output pc_i, ce_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
           upd_cond_i, upd_mispred_i, invalidate_i,
    input  next_pc_o, next_taken_o, stat_upd_o, stat_mispred_o
  );
  modport slave(
    input  pc_i, ce_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
           upd_cond_i, upd_mispred_i, invalidate_i,
    output next_pc_o, next_taken_o, stat_upd_o, stat_mispred_o
  );
endinterface

// File: rtl/bpu.sv
// bpu: direct-mapped BTB with 2-bit counters, zero-latency next-PC prediction and stats
module bpu #(
  parameter int         XLEN    = 32,
  parameter int         IDX_W   = 4,
  parameter logic [1:0] CTR_RST = 2'b01
) (
  input logic   clk_i,
  input logic   rst_i,
  bpu_if.slave  bus
);
  localparam int N     = 2 ** IDX_W;
  localparam int TAG_W = XLEN - IDX_W - 2;
  logic [N-1:0]      valid, uncond;
  logic [TAG_W-1:0]  tag    [N];
  logic [XLEN-1:0]   target [N];
  logic [1:0]        ctr    [N];
  logic [IDX_W-1:0]  idx, u_idx;
  logic              hit, u_hit, taken;
  logic [31:0]       upd_q, mis_q;
  assign idx   = bus.pc_i[IDX_W+1:2];
  assign u_idx = bus.upd_pc_i[IDX_W+1:2];
  assign hit   = valid[idx] && tag[idx] == bus.pc_i[XLEN-1:IDX_W+2];
  assign u_hit = valid[u_idx] && tag[u_idx] == bus.upd_pc_i[XLEN-1:IDX_W+2];
  assign taken = bus.ce_i && hit && (uncond[idx] || ctr[idx][1]);
  assign bus.next_taken_o   = taken;
  assign bus.next_pc_o      = taken ? target[idx] : bus.pc_i + XLEN'(4);
  assign bus.stat_upd_o     = upd_q;
  assign bus.stat_mispred_o = mis_q;
  // invalidate wins over a same-edge update; the table reads above see pre-update state
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      valid  <= '0;
      uncond <= '0;
      for (int i = 0; i < N; i++) begin
        ctr[i]    <= CTR_RST;
        tag[i]    <= '0;
        target[i] <= '0;
      end
    end else if (bus.invalidate_i) begin
      valid <= '0;
      for (int i = 0; i < N; i++) ctr[i] <= CTR_RST;
    end else if (bus.upd_valid_i) begin
      if (u_hit && bus.upd_cond_i) begin
        ctr[u_idx]    <= bus.upd_taken_i ? (ctr[u_idx] == 2'b11 ? 2'b11 : ctr[u_idx] + 2'd1)
                                         : (ctr[u_idx] == 2'b00 ? 2'b00 : ctr[u_idx] - 2'd1);
        uncond[u_idx] <= 1'b0;
        if (bus.upd_taken_i) target[u_idx] <= bus.upd_target_i;
      end else if (u_hit) begin
        target[u_idx] <= bus.upd_target_i;
        uncond[u_idx] <= 1'b1;
      end else if (bus.upd_taken_i) begin
        valid[u_idx]  <= 1'b1;
        tag[u_idx]    <= bus.upd_pc_i[XLEN-1:IDX_W+2];
        target[u_idx] <= bus.upd_target_i;
        ctr[u_idx]    <= 2'b10;
        uncond[u_idx] <= !bus.upd_cond_i;
      end
    end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      upd_q <= '0;
      mis_q <= '0;
    end else if (bus.upd_valid_i) begin
      upd_q <= upd_q + 32'(~&upd_q);
      mis_q <= mis_q + 32'(bus.upd_mispred_i && !(&mis_q));
    end
endmodule

// File: tb/tb_bpu.sv
// tb_bpu: directed scenario tests for the branch prediction unit
module tb_bpu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  bpu_if #(.XLEN(32)) b();
  bpu dut (.clk_i(clk), .rst_i(rst), .bus(b));
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_upd = 0;
  logic [31:0] exp_mis = 0;

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                     input logic cond, input logic mis, input logic inv);
    b.upd_valid_i = 1; b.upd_pc_i = pc; b.upd_taken_i = tk; b.upd_target_i = tgt;
    b.upd_cond_i = cond; b.upd_mispred_i = mis; b.invalidate_i = inv;
    @(posedge clk); #1;
    b.upd_valid_i = 0; b.upd_mispred_i = 0; b.invalidate_i = 0;
    exp_upd = (&exp_upd) ? exp_upd : exp_upd + 1;
    if (mis) exp_mis = (&exp_mis) ? exp_mis : exp_mis + 1;
  endtask

  task automatic set_pc(input logic [31:0] pc, input logic ce);
    b.pc_i = pc; b.ce_i = ce; #1;
  endtask

  task automatic test_reset;
    b.pc_i = 32'h100; b.ce_i = 1; b.upd_valid_i = 0; b.upd_pc_i = 0; b.upd_taken_i = 0;
    b.upd_target_i = 0; b.upd_cond_i = 0; b.upd_mispred_i = 0; b.invalidate_i = 0;
    #1;
    checks++; if (b.next_pc_o !== 32'h104) begin errors++; $display("FAIL reset_next_pc got %h exp %h", b.next_pc_o, 32'h104); end
    checks++; if (b.next_taken_o !== 1'b0) begin errors++; $display("FAIL reset_taken got %b exp 0", b.next_taken_o); end
    b.upd_valid_i = 1; b.upd_pc_i = 32'h100; b.upd_taken_i = 1; b.upd_target_i = 32'h200;
    b.upd_cond_i = 1; b.upd_mispred_i = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (b.stat_upd_o !== 0 || b.stat_mispred_o !== 0) begin errors++; $display("FAIL reset_stats got %h/%h exp 0/0", b.stat_upd_o, b.stat_mispred_o); end
    checks++; if (b.next_pc_o !== 32'h104) begin errors++; $display("FAIL reset_no_alloc got %h exp %h", b.next_pc_o, 32'h104); end
    b.upd_valid_i = 0; b.upd_mispred_i = 0;
    @(negedge clk); #2 rst = 0; #1;
    checks++; if (b.stat_upd_o !== 0 || b.stat_mispred_o !== 0) begin errors++; $display("FAIL release_stats got %h/%h exp 0/0", b.stat_upd_o, b.stat_mispred_o); end
    @(posedge clk); #1;
    checks++; if (b.stat_upd_o !== 0 || b.stat_mispred_o !== 0) begin errors++; $display("FAIL post_release_stats got %h/%h exp 0/0", b.stat_upd_o, b.stat_mispred_o); end
  endtask

  task automatic test_train;
    upd(32'h100, 1, 32'h200, 1, 1, 0);
    set_pc(32'h100, 1);
    checks++; if (b.next_pc_o !== 32'h200 || b.next_taken_o !== 1) begin errors++; $display("FAIL alloc_pred got %h/%b exp 00000200/1", b.next_pc_o, b.next_taken_o); end
    checks++; if (b.stat_upd_o !== 1 || b.stat_mispred_o !== 1) begin errors++; $display("FAIL first_stats got %h/%h exp 1/1", b.stat_upd_o, b.stat_mispred_o); end
    upd(32'h100, 0, 32'h0, 1, 1, 0);
    checks++; if (b.next_pc_o !== 32'h104 || b.next_taken_o !== 0) begin errors++; $display("FAIL ctr01_pred got %h/%b exp 00000104/0", b.next_pc_o, b.next_taken_o); end
    upd(32'h100, 0, 32'h0, 1, 0, 0);
    checks++; if (b.next_pc_o !== 32'h104 || b.next_taken_o !== 0) begin errors++; $display("FAIL ctr00_pred got %h/%b exp 00000104/0", b.next_pc_o, b.next_taken_o); end
    upd(32'h100, 1, 32'h240, 1, 0, 0);
    checks++; if (b.next_pc_o !== 32'h104 || b.next_taken_o !== 0) begin errors++; $display("FAIL ctr_up01_pred got %h/%b exp 00000104/0", b.next_pc_o, b.next_taken_o); end
    upd(32'h100, 1, 32'h240, 1, 0, 0);
    checks++; if (b.next_pc_o !== 32'h240 || b.next_taken_o !== 1) begin errors++; $display("FAIL ctr_up10_pred got %h/%b exp 00000240/1", b.next_pc_o, b.next_taken_o); end
    upd(32'h100, 1, 32'h240, 1, 0, 0);
    upd(32'h100, 1, 32'h240, 1, 0, 0);
    upd(32'h100, 0, 32'h0, 1, 0, 0);
    checks++; if (b.next_pc_o !== 32'h240 || b.next_taken_o !== 1) begin errors++; $display("FAIL ctr_sat_hi got %h/%b exp 00000240/1", b.next_pc_o, b.next_taken_o); end
  endtask

  task automatic test_alias;
    upd(32'h140, 1, 32'h300, 1, 0, 0);
    set_pc(32'h100, 1);
    checks++; if (b.next_pc_o !== 32'h104 || b.next_taken_o !== 0) begin errors++; $display("FAIL alias_old got %h/%b exp 00000104/0", b.next_pc_o, b.next_taken_o); end
    set_pc(32'h140, 1);
    checks++; if (b.next_pc_o !== 32'h300 || b.next_taken_o !== 1) begin errors++; $display("FAIL alias_new got %h/%b exp 00000300/1", b.next_pc_o, b.next_taken_o); end
  endtask

  task automatic test_jal_invalidate;
    upd(32'h80, 1, 32'h40, 1, 0, 0);
    upd(32'h80, 0, 32'h0, 1, 0, 0);
    upd(32'h80, 0, 32'h0, 1, 0, 0);
    set_pc(32'h80, 1);
    checks++; if (b.next_pc_o !== 32'h84 || b.next_taken_o !== 0) begin errors++; $display("FAIL jal_pre got %h/%b exp 00000084/0", b.next_pc_o, b.next_taken_o); end
    upd(32'h80, 1, 32'h44, 0, 0, 0);
    checks++; if (b.next_pc_o !== 32'h44 || b.next_taken_o !== 1) begin errors++; $display("FAIL jal_uncond got %h/%b exp 00000044/1", b.next_pc_o, b.next_taken_o); end
    set_pc(32'h80, 0);
    checks++; if (b.next_pc_o !== 32'h84 || b.next_taken_o !== 0) begin errors++; $display("FAIL ce_off got %h/%b exp 00000084/0", b.next_pc_o, b.next_taken_o); end
    upd(32'h104, 1, 32'h500, 1, 0, 0);
    set_pc(32'h104, 1);
    checks++; if (b.next_pc_o !== 32'h500 || b.next_taken_o !== 1) begin errors++; $display("FAIL idx1_alloc got %h/%b exp 00000500/1", b.next_pc_o, b.next_taken_o); end
    upd(32'h80, 1, 32'h60, 1, 1, 1);
    checks++; if (b.next_pc_o !== 32'h108 || b.next_taken_o !== 0) begin errors++; $display("FAIL inv_idx1 got %h/%b exp 00000108/0", b.next_pc_o, b.next_taken_o); end
    set_pc(32'h80, 1);
    checks++; if (b.next_pc_o !== 32'h84 || b.next_taken_o !== 0) begin errors++; $display("FAIL inv_drop_upd got %h/%b exp 00000084/0", b.next_pc_o, b.next_taken_o); end
    checks++; if (b.stat_upd_o !== exp_upd || b.stat_mispred_o !== exp_mis) begin errors++; $display("FAIL inv_stats got %h/%h exp %h/%h", b.stat_upd_o, b.stat_mispred_o, exp_upd, exp_mis); end
  endtask

  task automatic test_same_cycle;
    upd(32'h100, 1, 32'h200, 1, 0, 0);
    upd(32'h100, 0, 32'h0, 1, 0, 0);
    b.pc_i = 32'h100; b.ce_i = 1;
    b.upd_valid_i = 1; b.upd_pc_i = 32'h100; b.upd_taken_i = 1; b.upd_target_i = 32'h220; b.upd_cond_i = 1;
    #1;
    checks++; if (b.next_pc_o !== 32'h104 || b.next_taken_o !== 0) begin errors++; $display("FAIL same_cycle_old got %h/%b exp 00000104/0", b.next_pc_o, b.next_taken_o); end
    @(posedge clk); #1;
    b.upd_valid_i = 0;
    exp_upd = exp_upd + 1;
    checks++; if (b.next_pc_o !== 32'h220 || b.next_taken_o !== 1) begin errors++; $display("FAIL same_cycle_new got %h/%b exp 00000220/1", b.next_pc_o, b.next_taken_o); end
  endtask

  task automatic test_stats;
    checks++; if (b.stat_upd_o !== exp_upd || b.stat_mispred_o !== exp_mis) begin errors++; $display("FAIL stats_count got %h/%h exp %h/%h", b.stat_upd_o, b.stat_mispred_o, exp_upd, exp_mis); end
    b.upd_mispred_i = 1;
    @(posedge clk); #1;
    b.upd_mispred_i = 0;
    checks++; if (b.stat_upd_o !== exp_upd || b.stat_mispred_o !== exp_mis) begin errors++; $display("FAIL mispred_no_valid got %h/%h exp %h/%h", b.stat_upd_o, b.stat_mispred_o, exp_upd, exp_mis); end
    @(negedge clk);
    force dut.upd_q = 32'hFFFF_FFFE;
    force dut.mis_q = 32'hFFFF_FFFE;
    #1;
    release dut.upd_q;
    release dut.mis_q;
    exp_upd = 32'hFFFF_FFFE;
    exp_mis = 32'hFFFF_FFFE;
    upd(32'h900, 0, 32'h0, 1, 1, 0);
    checks++; if (b.stat_upd_o !== 32'hFFFF_FFFF || b.stat_mispred_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL stats_max got %h/%h exp ffffffff/ffffffff", b.stat_upd_o, b.stat_mispred_o); end
    upd(32'h900, 0, 32'h0, 1, 1, 0);
    checks++; if (b.stat_upd_o !== 32'hFFFF_FFFF || b.stat_mispred_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL stats_sat got %h/%h exp ffffffff/ffffffff", b.stat_upd_o, b.stat_mispred_o); end
  endtask

  task automatic test_wrap;
    set_pc(32'hFFFF_FFFC, 1);
    checks++; if (b.next_pc_o !== 32'h0 || b.next_taken_o !== 0) begin errors++; $display("FAIL wrap_fffc got %h/%b exp 00000000/0", b.next_pc_o, b.next_taken_o); end
    set_pc(32'hFFFF_FFFF, 1);
    checks++; if (b.next_pc_o !== 32'h3 || b.next_taken_o !== 0) begin errors++; $display("FAIL wrap_ffff got %h/%b exp 00000003/0", b.next_pc_o, b.next_taken_o); end
  endtask

  initial begin
    test_reset;
    test_train;
    test_alias;
    test_jal_invalidate;
    test_same_cycle;
    test_stats;
    test_wrap;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
